// File: rtl/esp32_uart_pkg.sv
// Shared definitions for the ESP32 UART Lite link: register map, status bits,
// AXI response codes and the TX master state encoding.
package esp32_uart_pkg;

    localparam logic [3:0] REG_RX_ADDR   = 4'h0;
    localparam logic [3:0] REG_TX_ADDR   = 4'h4;
    localparam logic [3:0] REG_STAT_ADDR = 4'h8;
    localparam logic [3:0] REG_CTRL_ADDR = 4'hC;

    localparam int unsigned STAT_RX_VALID_BIT = 0;
    localparam int unsigned STAT_TX_FULL_BIT  = 3;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_STAT_AR,
        TX_STAT_R,
        TX_WR,
        TX_B
    } tx_state_e;

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/esp32_uart_tx_fifo.sv
// Synchronous FIFO for the UART TX input path. Full/empty come from a wrap bit
// on the read/write pointers; one_o flags exactly one stored entry.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             one_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = 1;

    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      level;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign level   = wr_q - rd_q;
    assign one_o   = (level == ONE);
    assign data_o  = mem_q[rd_q[PW-1:0]];

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i && !full_o) wr_d = wr_q + 1'b1;
        if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/esp32_uart_tx_axil.sv
// AXI4-Lite write-side master feeding bytes to the UART Lite TX FIFO.
// Polls the status register until TX is not full, writes the byte, waits for B.
// Define UART_TX_FIFO_EN to replace the single holding register by a
// FIFO_DEPTH-entry input FIFO.
module esp32_uart_tx_axil
    import esp32_uart_pkg::*;
#(
    parameter int unsigned AXI_DATA_W  = 32,
    parameter logic [3:0]  STAT_ADDR   = REG_STAT_ADDR,
    parameter logic [3:0]  TX_ADDR     = REG_TX_ADDR,
    parameter int unsigned TX_FULL_BIT = STAT_TX_FULL_BIT,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic [3:0]              araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_DATA_W/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    tx_state_e  state_q, state_d;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic       err_q, err_d;
    logic       push, pop;
    logic       buf_empty, buf_full, buf_more;
    logic [7:0] buf_data;
    logic       unused_ok;

    assign tx_ready = !rst && !buf_full;
    assign push     = tx_valid && tx_ready;
    assign pop      = (state_q == TX_B) && bvalid;
    assign busy     = (state_q != TX_IDLE) || !buf_empty;
    assign err      = err_q;

`ifdef UART_TX_FIFO_EN
    logic fifo_one;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (tx_data),
        .pop_i   (pop),
        .data_o  (buf_data),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .one_o   (fifo_one)
    );

    assign buf_more  = !buf_empty && !fifo_one;
    assign unused_ok = ^{rdata, rresp[0], bresp[0]};
`else
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_q, hold_d;

    // Single holding register: filled on accept, emptied on write response.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (pop) hold_vld_d = 1'b0;
        if (push) begin
            hold_vld_d = 1'b1;
            hold_d     = tx_data;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign buf_empty = !hold_vld_q;
    assign buf_full  = hold_vld_q;
    assign buf_more  = 1'b0;
    assign buf_data  = hold_q;
    assign unused_ok = ^{rdata, rresp[0], bresp[0], 32'(FIFO_DEPTH)};
`endif

    // State, write-handshake flags and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Next state; IDLE also reacts to a same-cycle accept so arvalid follows
    // the accepting edge directly.
    always_comb begin
        state_d   = state_q;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        err_d     = err_clr ? 1'b0 : err_q;
        unique case (state_q)
            TX_IDLE:    if (!buf_empty || push) state_d = TX_STAT_AR;
            TX_STAT_AR: if (arready) state_d = TX_STAT_R;
            TX_STAT_R: begin
                if (rvalid) begin
                    if (resp_is_err(rresp)) begin
                        err_d   = 1'b1;
                        state_d = TX_STAT_AR;
                    end else if (rdata[TX_FULL_BIT]) begin
                        state_d = TX_STAT_AR;
                    end else begin
                        state_d = TX_WR;
                    end
                end
            end
            TX_WR: begin
                aw_done_d = aw_done_q || awready;
                w_done_d  = w_done_q || wready;
                if (aw_done_d && w_done_d) state_d = TX_B;
            end
            TX_B: begin
                if (bvalid) begin
                    if (resp_is_err(bresp)) err_d = 1'b1;
                    state_d = (buf_more || push) ? TX_STAT_AR : TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // AXI channel outputs decoded from state.
    always_comb begin
        arvalid = (state_q == TX_STAT_AR);
        araddr  = arvalid ? STAT_ADDR : '0;
        rready  = (state_q == TX_STAT_R);
        awvalid = (state_q == TX_WR) && !aw_done_q;
        awaddr  = awvalid ? TX_ADDR : '0;
        wvalid  = (state_q == TX_WR) && !w_done_q;
        wdata   = '0;
        wstrb   = '0;
        if (wvalid) begin
            wdata[7:0] = buf_data;
            wstrb[0]   = 1'b1;
        end
        bready  = (state_q == TX_B);
    end

endmodule

// File: doc/esp32_uart_tx_axil.md
Name: esp32_uart_tx_axil

Overview:
AXI4-Lite write-side master that feeds bytes into the UART Lite peripheral's TX FIFO, toward the ESP32 link. It accepts bytes on a valid/ready stream and polls the peripheral status register until the TX FIFO is not full. It then writes each byte to the TX FIFO register and waits for the write response. It sits beside the RX controller on the same AXI-Lite slave; each block owns its own channels.

Parameters:
- AXI_DATA_W, 32, AXI-Lite data width. Only bits [7:0] carry payload.
- STAT_ADDR, 4'h8, status register address.
- TX_ADDR, 4'h4, TX FIFO register address.
- TX_FULL_BIT, 3, index of the TX-FIFO-full flag in the status word.
- FIFO_DEPTH, 4, input FIFO depth. Power of two, at least 2. Used only when UART_TX_FIFO_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  block can accept a byte
- busy  out  1  an AXI transaction is in progress or a byte is buffered
- err  out  1  sticky error: a SLVERR/DECERR response was seen
- err_clr  in  1  clears err
- araddr  out  4  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  AXI_DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  4  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  AXI_DATA_W  write data
- wstrb  out  AXI_DATA_W/8  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is clk. Assertion immediately forces:
  - state IDLE;
  - all valid outputs and rready/bready to 0;
  - err 0, busy 0, tx_ready 0 while rst is high;
  - holding register/FIFO empty.
- Reset mid-transaction: the in-flight byte is discarded with no completion attempt.
- Input handshake: a byte is accepted on a cycle with tx_valid && tx_ready. Without the FIFO, tx_ready = 1 only while the holding register is empty.
- States:
  - IDLE: waits for a buffered byte. Once one is present, the next cycle enters STAT_AR.
    - Latency: byte accepted at cycle N, arvalid high at N+1.
  - STAT_AR: arvalid=1, araddr=STAT_ADDR. On arready, go to STAT_R.
  - STAT_R: rready=1. On rvalid:
    - rresp[1]=1: set err, go to STAT_AR (retry).
    - rdata[TX_FULL_BIT]=1: go to STAT_AR (poll again).
    - otherwise: go to WR.
  - WR: awvalid and wvalid are asserted together, with:
    - awaddr=TX_ADDR;
    - wdata = zero-extended byte;
    - wstrb = 1 in bit 0 only.
    Each valid drops independently on its own handshake. Both handshakes may complete in the same or different cycles, in either order. When both have completed, go to B.
  - B: bready=1. On bvalid:
    - pop the byte;
    - if bresp[1]=1, set err (the byte is not retried);
    - go to IDLE, or directly to STAT_AR if another byte is buffered.
- AXI rules:
  - Every valid holds until its ready.
  - Address and data stay stable while valid is high.
  - araddr and awaddr are 0 when not valid.
- busy = (state != IDLE) || buffer non-empty.
- err: sticky. err_clr clears it. If a set and err_clr occur in the same cycle, the set wins.
- Simultaneous input accept and pop in B: both take effect, so occupancy is unchanged.

Optional Feature:
- UART_TX_FIFO_EN defined: the input buffer is a FIFO_DEPTH-entry FIFO.
  - tx_ready = !full.
  - Bytes are sent in arrival order.
  - Full and empty are tracked with a wrap bit.
- Not defined: a single holding register, giving at most one outstanding byte.

Decomposition:
- Shared package esp32_uart_pkg:
  - register address constants (RX=0x0, TX=0x4, STAT=0x8, CTRL=0xC);
  - status bit indices (RX_VALID=0, TX_FULL=3);
  - AXI resp enum (OKAY, EXOKAY, SLVERR, DECERR);
  - tx state enum.
- Sub-module uart_tx_fifo: sync FIFO with push/pop/full/empty, instantiated only under UART_TX_FIFO_EN.

Test Plan:
- Single byte: send 0x5A; status rdata=0x00 → awaddr 0x4, wdata 0x0000005A, wstrb 0x1, then bready. err=0, busy falls after bvalid.
- TX full polling: status returns 0x08 three times, then 0x00 → exactly 4 AR transactions and 1 write, and tx_ready low throughout (no FIFO).
- Split handshakes: awready 2 cycles before wready, then the reverse order → one write only, each valid dropped on its own handshake, B entered only after both complete.
- Error: bresp=2'b10 → err=1, byte dropped, the next byte proceeds. err_clr pulse → err=0. rresp=2'b11 on status → err=1 and status re-polled.
- Reset mid-WR: assert rst while awvalid=1 → awvalid/wvalid low the same cycle, busy=0. After release, a new byte 0xA5 is sent normally.
- FIFO (UART_TX_FIFO_EN, depth 4): burst 0x01..0x05 with awready held low → tx_ready drops after 4 accepts. Writes then occur in order 0x01..0x04, with 0x05 accepted once space frees.
